// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_1_4_stream_slot.sv
// One-entry output buffer with a delivered-word counter for a single channel.
module stream_slot #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  always_comb begin
    drain  = full_q & rd_ready;
    // A write in the same cycle as a drain keeps the slot full (pass-through refill).
    full_d = wr_en | (full_q & ~rd_ready);
    data_d = wr_en ? wr_data : data_q;
    cnt_d  = drain ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = full_q;
  assign data  = data_q;
  assign cnt   = cnt_q;
endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer: routes each accepted word to the slot chosen by in_sel.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  sel_t                   in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT*CNT_W-1:0] out_cnt
);
  logic [N_OUT-1:0] wr_en;
  logic             accept;

  always_comb begin
    // The selected slot can take a word if empty or draining this cycle.
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    accept   = in_valid & in_ready;
    wr_en    = '0;
    wr_en[in_sel] = accept;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    stream_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .wr_data (in_data),
      .rd_ready(out_ready[k]),
      .valid   (out_valid[k]),
      .data    (out_data[k*WIDTH +: WIDTH]),
      .cnt     (out_cnt[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed plus randomized bench for demux_1_4_stream against an array-based model.
module tb_demux_1_4_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: one buffered word, a full flag and a counter per channel.
  bit         m_full [4];
  logic [3:0] m_data [4];
  int         m_cnt  [4];

  demux_1_4_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0;
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [3:0]  ev;
    logic [15:0] ed;
    logic [31:0] ec;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = m_full[k];
      ed[k*4 +: 4]   = m_data[k];
      ec[k*8 +: 8]   = 8'(m_cnt[k] % 256);
    end
    chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".data"},  64'(out_data),  64'(ed));
    chk({tag, ".cnt"},   64'(out_cnt),   64'(ec));
  endtask

  // One clock cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input logic v, input logic [1:0] sel, input logic [3:0] d,
                      input logic [3:0] ordy, input string tag);
    bit acc;
    @(negedge clk);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_full[sel] || ordy[sel]));
    acc = v && (!m_full[sel] || ordy[sel]);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (m_full[k] && ordy[k]) begin
        m_cnt[k]++;
        m_full[k] = 0;
      end
    end
    if (acc) begin
      m_full[sel] = 1;
      m_data[sel] = d;
    end
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-operation discards slot 2 without a clock edge.
    step(1'b1, 2'd2, 4'h9, 4'b0000, "fill2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst.valid", 64'(out_valid), 64'h0);
    chk("arst.data",  64'(out_data),  64'h0);
    chk("arst.cnt",   64'(out_cnt),   64'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_sel = 2'd2;
    #1;
    chk("arst.in_ready", 64'(in_ready), 64'h1);

    // Single stalled word stays put.
    step(1'b1, 2'd2, 4'hA, 4'b0000, "single");
    chk("single.valid_lit", 64'(out_valid), 64'h4);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd2, 4'(i), 4'b0000, "hold2");
      chk("hold2.data_lit", 64'(out_data[11:8]), 64'hA);
    end
    step(1'b0, 2'd0, 4'h0, 4'b0000, "ready_sel0");

    // Back-to-back words through channel 1.
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 2'd1, 4'(i), 4'b0010, "b2b");
      chk("b2b.data_lit", 64'(out_data[7:4]), 64'(i));
    end
    step(1'b0, 2'd1, 4'h0, 4'b0010, "b2b_tail");
    chk("b2b.cnt1_lit", 64'(out_cnt[15:8]), 64'd4);

    // Drain and refill of slot 3 in the same cycle.
    step(1'b1, 2'd3, 4'h5, 4'b0000, "fill3");
    step(1'b1, 2'd3, 4'h6, 4'b1000, "passthru");
    chk("passthru.data_lit", 64'(out_data[15:12]), 64'h6);
    chk("passthru.cnt3_lit", 64'(out_cnt[31:24]), 64'd1);

    // 256 transfers through channel 0 wrap its counter back to the start value.
    step(1'b1, 2'd0, 4'h1, 4'b0000, "prefill0");
    c0 = m_cnt[0];
    for (int i = 0; i < 256; i++) step(1'b1, 2'd0, 4'($urandom), 4'b0001, "wrap");
    chk("wrap.cnt0_lit", 64'(out_cnt[7:0]), 64'(8'(c0)));

    // Independent channels.
    step(1'b0, 2'd0, 4'h0, 4'b1111, "flush");
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 4'(i + 1), 4'b0000, "fillall");
    chk("indep.v1111", 64'(out_valid), 64'hF);
    step(1'b0, 2'd0, 4'h0, 4'b1000, "pulse3");
    chk("indep.v0111", 64'(out_valid), 64'h7);
    step(1'b0, 2'd0, 4'h0, 4'b0010, "pulse1");
    chk("indep.v0101", 64'(out_valid), 64'h5);
    chk("indep.d0", 64'(out_data[3:0]), 64'h1);
    chk("indep.d2", 64'(out_data[11:8]), 64'h3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
